// File: rtl/bonus_ship_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bonus_ship_pkg
// Description : Shared types and constants for the bonus ship scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package bonus_ship_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_FLYING  = 2'd2,
        ST_EXPLODE = 2'd3
    } bonus_state_t;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int unsigned SCORE_ENTRIES = 15;

    localparam logic [8:0] SCORE_TABLE [SCORE_ENTRIES] = '{
        9'd100, 9'd50,  9'd50,  9'd100, 9'd150,
        9'd100, 9'd100, 9'd50,  9'd300, 9'd100,
        9'd100, 9'd100, 9'd50,  9'd150, 9'd100
    };

    function automatic logic [8:0] score_lookup(input logic [3:0] idx);
        score_lookup = 9'd0;
        if (idx < 4'(SCORE_ENTRIES)) begin
            score_lookup = SCORE_TABLE[idx];
        end
    endfunction

endpackage : bonus_ship_pkg
`default_nettype wire

// File: rtl/bonus_ship_scheduler_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : lfsr16
// Description : Free-running seeded 16-bit Fibonacci LFSR.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr16
    import bonus_ship_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] value_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        feedback;

    assign feedback = ^(lfsr_q & LFSR_TAPS);
    assign lfsr_d   = {lfsr_q[14:0], feedback};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;

endmodule : lfsr16
`default_nettype wire

// File: rtl/bonus_ship_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : bonus_ship_scheduler
// Description : Bonus ship pass sequencing: spawn timing, direction, life,
//               explosion window and hit scoring.
// Revision    : 1.0 - initial release
// ============================================================================
module bonus_ship_scheduler
    import bonus_ship_pkg::*;
#(
    parameter int unsigned MIN_DELAY_FRAMES = 600,
    parameter int unsigned DELAY_RANGE_BITS = 9,
    parameter int unsigned EXPLODE_FRAMES   = 30,
    parameter int unsigned LOW_LIMIT_Y      = 320,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        playGame,
    input  logic        bonusFireCollision,
    input  logic        shipExited,
    input  logic        playerShot,
    input  logic [10:0] alienMatrixYPosition,
    output logic        spawn,
    output logic        spawnDirRight,
    output logic        shipActive,
    output logic        explodeActive,
    output logic        scoreValid,
    output logic [8:0]  scoreValue
);

    bonus_state_t state_q, state_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [3:0]   shot_q, shot_d;
    logic         spawn_q, spawn_d;
    logic         dir_q, dir_d;
    logic         score_valid_q, score_valid_d;
    logic [8:0]   score_value_q, score_value_d;

    logic [15:0]  lfsr_value;
    logic [15:0]  delay_w;
    logic         aliens_high_w;
    logic         lfsr_unused;

    lfsr16 #(
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .value_o (lfsr_value)
    );

    assign lfsr_unused   = ^lfsr_value[15:DELAY_RANGE_BITS];
    assign delay_w       = 16'(MIN_DELAY_FRAMES) + 16'(lfsr_value[DELAY_RANGE_BITS-1:0]);
    assign aliens_high_w = (alienMatrixYPosition <= 11'(LOW_LIMIT_Y));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shot_d        = shot_q;
        spawn_d       = 1'b0;
        dir_d         = dir_q;
        score_valid_d = 1'b0;
        score_value_d = score_value_q;

        if (playerShot) begin
            shot_d = (shot_q == 4'(SCORE_ENTRIES - 1)) ? 4'd0 : shot_q + 4'd1;
        end

        // Leaving the game overrides every in-flight transition and pulse
        if (!playGame) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT;
                    cnt_d   = delay_w;
                end
                ST_WAIT: begin
                    if (startOfFrame) begin
                        if (cnt_q != 16'd0) begin
                            cnt_d = cnt_q - 16'd1;
                        end else if (aliens_high_w) begin
                            state_d = ST_FLYING;
                            spawn_d = 1'b1;
                            dir_d   = shot_q[0];
                        end
                    end
                end
                ST_FLYING: begin
                    if (bonusFireCollision) begin
                        state_d       = ST_EXPLODE;
                        score_valid_d = 1'b1;
                        score_value_d = score_lookup(shot_q);
                        cnt_d         = 16'(EXPLODE_FRAMES - 1);
                    end else if (shipExited) begin
                        state_d = ST_WAIT;
                        cnt_d   = delay_w;
                    end
                end
                ST_EXPLODE: begin
                    if (startOfFrame) begin
                        if (cnt_q == 16'd0) begin
                            state_d = ST_WAIT;
                            cnt_d   = delay_w;
                        end else begin
                            cnt_d = cnt_q - 16'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (state_q == ST_IDLE) begin
            shot_d = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 16'd0;
            shot_q        <= 4'd0;
            spawn_q       <= 1'b0;
            dir_q         <= 1'b0;
            score_valid_q <= 1'b0;
            score_value_q <= 9'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shot_q        <= shot_d;
            spawn_q       <= spawn_d;
            dir_q         <= dir_d;
            score_valid_q <= score_valid_d;
            score_value_q <= score_value_d;
        end
    end

    assign spawn         = spawn_q;
    assign spawnDirRight = dir_q;
    assign shipActive    = (state_q == ST_FLYING);
    assign explodeActive = (state_q == ST_EXPLODE);
    assign scoreValid    = score_valid_q;
    assign scoreValue    = score_value_q;

endmodule : bonus_ship_scheduler
`default_nettype wire

// File: tb/tb_bonus_ship_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_bonus_ship_scheduler
// Description : Scenario testbench for bonus_ship_scheduler with a score queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bonus_ship_scheduler;
    import bonus_ship_pkg::*;

    localparam int MIN_D = 4;
    localparam int EXPL  = 30;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sof = 1'b0;
    logic        playGame = 1'b0;
    logic        coll = 1'b0;
    logic        exited = 1'b0;
    logic        shot = 1'b0;
    logic [10:0] alienY = 11'd100;
    logic        spawn, spawnDirRight, shipActive, explodeActive, scoreValid;
    logic [8:0]  scoreValue;

    int checks = 0;
    int passes = 0;
    int spawn_count = 0;
    int score_count = 0;
    int model_shot = 0;
    int exp_q[$];
    int score_ref[15] = '{100, 50, 50, 100, 150, 100, 100, 50, 300, 100, 100, 100, 50, 150, 100};

    bonus_ship_scheduler #(
        .MIN_DELAY_FRAMES (MIN_D),
        .DELAY_RANGE_BITS (1),
        .EXPLODE_FRAMES   (EXPL),
        .LOW_LIMIT_Y      (320),
        .LFSR_SEED        (16'hACE1)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .startOfFrame         (sof),
        .playGame             (playGame),
        .bonusFireCollision   (coll),
        .shipExited           (exited),
        .playerShot           (shot),
        .alienMatrixYPosition (alienY),
        .spawn                (spawn),
        .spawnDirRight        (spawnDirRight),
        .shipActive           (shipActive),
        .explodeActive        (explodeActive),
        .scoreValid           (scoreValid),
        .scoreValue           (scoreValue)
    );

    always #5 clk = ~clk;

    // Score scoreboard: every score pulse must match the oldest expected entry
    always @(negedge clk) begin
        if (!reset) begin
            if (spawn) spawn_count++;
            if (scoreValid) begin
                score_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL score_unexpected: got pulse value %0d, expected no pulse", scoreValue);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (scoreValue !== 9'(e))
                        $display("FAIL score_value: got %0d expected %0d", scoreValue, e);
                    else
                        passes++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic frame();
        sof = 1'b1;
        step();
        sof = 1'b0;
        repeat (3) step();
    endtask

    task automatic shoot(input int n);
        for (int i = 0; i < n; i++) begin
            shot = 1'b1;
            step();
            shot = 1'b0;
            step();
            model_shot = (model_shot + 1) % 15;
        end
    endtask

    task automatic wait_spawn(input int max_frames, output int nframes);
        int start;
        start = spawn_count;
        nframes = 0;
        for (int i = 0; i < max_frames; i++) begin
            frame();
            nframes++;
            if (spawn_count != start) break;
        end
    endtask

    task automatic wait_explode_end(output int nframes);
        nframes = 0;
        for (int i = 0; i < 40; i++) begin
            frame();
            nframes++;
            if (!explodeActive) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if ({spawn, spawnDirRight, shipActive, explodeActive, scoreValid, scoreValue} !== 14'd0)
            $display("FAIL reset_outputs: got %b expected all zero",
                     {spawn, spawnDirRight, shipActive, explodeActive, scoreValid, scoreValue});
        else passes++;
        checks++;
        if (dut.state_q !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", dut.state_q, ST_IDLE);
        else passes++;
        checks++;
        if (dut.u_lfsr.lfsr_q !== 16'hACE1) $display("FAIL reset_lfsr: got %h expected ace1", dut.u_lfsr.lfsr_q);
        else passes++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_first_spawn();
        int n, start;
        alienY = 11'd100;
        playGame = 1'b1;
        step();
        checks++;
        if (dut.state_q !== ST_WAIT) $display("FAIL start_wait: got %0d expected %0d", dut.state_q, ST_WAIT);
        else passes++;
        start = spawn_count;
        wait_spawn(12, n);
        checks++;
        if (n < 5 || n > 6) $display("FAIL first_spawn_frame: got %0d expected 5 or 6", n);
        else passes++;
        checks++;
        if (spawn_count - start != 1) $display("FAIL spawn_pulse_width: got %0d cycles expected 1", spawn_count - start);
        else passes++;
        checks++;
        if (shipActive !== 1'b1 || spawnDirRight !== 1'b0)
            $display("FAIL first_flying: got active=%b dir=%b expected active=1 dir=0", shipActive, spawnDirRight);
        else passes++;
    endtask

    task automatic test_score_300();
        int n, start;
        shoot(8);
        alienY = 11'd400;
        exp_q.push_back(score_ref[model_shot]);
        start = score_count;
        coll = 1'b1;
        shot = 1'b1;
        step();
        coll = 1'b0;
        shot = 1'b0;
        model_shot = (model_shot + 1) % 15;
        checks++;
        if (score_count - start != 1 || shipActive !== 1'b0 || explodeActive !== 1'b1)
            $display("FAIL hit_response: got pulses=%0d active=%b explode=%b expected 1/0/1",
                     score_count - start, shipActive, explodeActive);
        else passes++;
        wait_explode_end(n);
        checks++;
        if (n != EXPL) $display("FAIL explode_length: got %0d frames expected %0d", n, EXPL);
        else passes++;
        checks++;
        if (dut.state_q !== ST_WAIT) $display("FAIL explode_exit: got state %0d expected %0d", dut.state_q, ST_WAIT);
        else passes++;
    endtask

    task automatic test_low_aliens();
        int start;
        logic [31:0] ms;
        start = spawn_count;
        repeat (8) frame();
        checks++;
        if (spawn_count != start || dut.state_q !== ST_WAIT)
            $display("FAIL low_aliens_hold: got spawns=%0d state=%0d expected 0 spawns in WAIT",
                     spawn_count - start, dut.state_q);
        else passes++;
        alienY = 11'd300;
        frame();
        ms = 32'(model_shot);
        checks++;
        if (spawn_count - start != 1 || shipActive !== 1'b1)
            $display("FAIL low_aliens_release: got spawns=%0d active=%b expected 1/1", spawn_count - start, shipActive);
        else passes++;
        checks++;
        if (spawnDirRight !== ms[0]) $display("FAIL spawn_dir: got %b expected %b", spawnDirRight, ms[0]);
        else passes++;
    endtask

    task automatic test_both_events();
        int n, start;
        exp_q.push_back(score_ref[model_shot]);
        start = score_count;
        coll = 1'b1;
        exited = 1'b1;
        step();
        coll = 1'b0;
        exited = 1'b0;
        checks++;
        if (score_count - start != 1 || explodeActive !== 1'b1 || dut.cnt_q !== 16'(EXPL - 1))
            $display("FAIL both_events: got pulses=%0d explode=%b cnt=%0d expected 1/1/%0d",
                     score_count - start, explodeActive, dut.cnt_q, EXPL - 1);
        else passes++;
        wait_explode_end(n);
        start = score_count;
        coll = 1'b1;
        step();
        coll = 1'b0;
        step();
        checks++;
        if (score_count != start || dut.state_q !== ST_WAIT || explodeActive !== 1'b0)
            $display("FAIL wait_collision_ignored: got pulses=%0d state=%0d explode=%b expected 0/WAIT/0",
                     score_count - start, dut.state_q, explodeActive);
        else passes++;
    endtask

    task automatic test_exit_and_drop();
        int n, start;
        wait_spawn(12, n);
        exited = 1'b1;
        step();
        exited = 1'b0;
        checks++;
        if (shipActive !== 1'b0 || dut.state_q !== ST_WAIT ||
            dut.cnt_q < 16'(MIN_D) || dut.cnt_q > 16'(MIN_D + 1))
            $display("FAIL ship_exit: got active=%b state=%0d cnt=%0d expected 0/WAIT/%0d..%0d",
                     shipActive, dut.state_q, dut.cnt_q, MIN_D, MIN_D + 1);
        else passes++;
        wait_spawn(12, n);
        exp_q.push_back(score_ref[model_shot]);
        start = score_count;
        coll = 1'b1;
        step();
        coll = 1'b0;
        frame();
        frame();
        playGame = 1'b0;
        step();
        checks++;
        if (explodeActive !== 1'b0 || shipActive !== 1'b0 || dut.state_q !== ST_IDLE)
            $display("FAIL drop_in_explode: got explode=%b active=%b state=%0d expected 0/0/IDLE",
                     explodeActive, shipActive, dut.state_q);
        else passes++;
        checks++;
        if (score_count - start != 1) $display("FAIL drop_score_pulses: got %0d expected 1", score_count - start);
        else passes++;
        model_shot = 0;
        step();
    endtask

    task automatic test_shot_wrap();
        int n, start;
        playGame = 1'b1;
        step();
        shoot(15);
        checks++;
        if (dut.shot_q !== 4'(model_shot)) $display("FAIL shot_wrap: got %0d expected %0d", dut.shot_q, model_shot);
        else passes++;
        wait_spawn(12, n);
        checks++;
        if (shipActive !== 1'b1 || spawnDirRight !== 1'b0)
            $display("FAIL wrap_spawn: got active=%b dir=%b expected 1/0", shipActive, spawnDirRight);
        else passes++;
        exp_q.push_back(score_ref[model_shot]);
        start = score_count;
        coll = 1'b1;
        step();
        coll = 1'b0;
        checks++;
        if (score_count - start != 1) $display("FAIL wrap_score_pulse: got %0d expected 1", score_count - start);
        else passes++;
    endtask

    task automatic test_reset_mid_flying();
        int n;
        wait_explode_end(n);
        wait_spawn(12, n);
        checks++;
        if (shipActive !== 1'b1) $display("FAIL pre_reset_flying: got %b expected 1", shipActive);
        else passes++;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (shipActive !== 1'b0) $display("FAIL async_reset: got active=%b expected 0", shipActive);
        else passes++;
        step();
        checks++;
        if ({spawn, spawnDirRight, shipActive, explodeActive, scoreValid, scoreValue} !== 14'd0 ||
            dut.state_q !== ST_IDLE || dut.u_lfsr.lfsr_q !== 16'hACE1)
            $display("FAIL mid_reset_state: got outs=%b state=%0d lfsr=%h expected 0/IDLE/ace1",
                     {spawn, spawnDirRight, shipActive, explodeActive, scoreValid, scoreValue},
                     dut.state_q, dut.u_lfsr.lfsr_q);
        else passes++;
        reset = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_first_spawn();
        test_score_300();
        test_low_aliens();
        test_both_events();
        test_exit_and_drop();
        test_shot_wrap();
        test_reset_mid_flying();
        checks++;
        if (exp_q.size() != 0) $display("FAIL score_queue_drain: got %0d pending expected 0", exp_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_bonus_ship_scheduler
`default_nettype wire

// File: doc/bonus_ship_scheduler.md
# bonus_ship_scheduler

Sequences the bonus (mystery) ship: decides when a pass starts and which direction it takes, tracks the ship's life, runs the explosion display window and produces the award score on a hit. It sits between the game-state logic and the bonus ship movement/drawing path. It drives that path's spawn and enable controls and consumes its collision and exit events. All timing is counted in frames (`startOfFrame` pulses).

## Interface
- `MIN_DELAY_FRAMES`, 600: minimum frames between end of a pass and the next spawn
- `DELAY_RANGE_BITS`, 9: width of the random extra delay (0..2^n-1 frames), legal range 1..15
- `EXPLODE_FRAMES`, 30: frames `explodeActive` stays high after a hit
- `LOW_LIMIT_Y`, 320: spawn is suppressed while `alienMatrixYPosition` > this value
- `LFSR_SEED`, 16'hACE1: reset value of the random generator (must be nonzero)
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `startOfFrame`  in  1  one-cycle pulse per frame
- `playGame`  in  1  high while a game is running
- `bonusFireCollision`  in  1  player shot hit the bonus ship (level, sampled every cycle)
- `shipExited`  in  1  movement block reports the ship has left the screen
- `playerShot`  in  1  one-cycle pulse per player shot fired
- `alienMatrixYPosition`  in  11  current top Y of the alien matrix
- `spawn`  out  1  one-cycle pulse that starts a pass
- `spawnDirRight`  out  1  direction for the pass, valid while `shipActive`
- `shipActive`  out  1  ship is flying (enables movement and drawing)
- `explodeActive`  out  1  explosion sprite window
- `scoreValid`  out  1  one-cycle pulse; `scoreValue` is valid in this cycle
- `scoreValue`  out  9  award points, unsigned

## Operation
- States: IDLE, WAIT, FLYING, EXPLODE. Reset puts the block in IDLE.
- Reset values:
  - All outputs are 0.
  - Frame counter = 0, shot counter = 0, LFSR = `LFSR_SEED`.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle regardless of state.
- Delay load: frame counter ← `MIN_DELAY_FRAMES` + LFSR[`DELAY_RANGE_BITS`-1:0]. Width is 16 bits, with no overflow for legal parameters.
- IDLE → WAIT when `playGame`=1, loading the delay.
- WAIT, on `startOfFrame`:
  - If the counter ≠ 0, decrement it.
  - If the counter = 0 and `alienMatrixYPosition` ≤ `LOW_LIMIT_Y`, go to FLYING and pulse `spawn`.
  - If the counter = 0 but the aliens are too low, stay in WAIT and retry on each later frame.
- On entering FLYING: `spawnDirRight` ← shot counter bit 0.
- FLYING:
  - `bonusFireCollision` → EXPLODE. Pulse `scoreValid` and load the explode counter with `EXPLODE_FRAMES`-1.
  - `shipExited` → WAIT and reload the delay.
  - If both events occur in the same cycle, collision wins.
- EXPLODE:
  - `explodeActive`=1.
  - The counter decrements on each `startOfFrame`.
  - On `startOfFrame` with the counter at 0: go to WAIT and reload the delay.
- `bonusFireCollision` and `shipExited` are ignored outside FLYING.
- Shot counter: 4 bits, +1 per `playerShot`, wraps 14→0 (mod 15). It is cleared in IDLE.
- Score: `scoreValue` = SCORE_TABLE[shot counter] sampled at the hit. `scoreValue` holds until the next hit.
- `playGame`=0 in any state → IDLE on the next cycle. In that case:
  - `shipActive` and `explodeActive` drop.
  - No `spawn` or `scoreValid` pulse is issued.
- `shipActive`=1 exactly while in FLYING.

## Timing
- All outputs are registered.
- `spawn` and `shipActive` rise in the cycle after the qualifying `startOfFrame`.
- `scoreValid` is high in the cycle after the collision is sampled. `shipActive` falls and `explodeActive` rises in that same cycle.
- First spawn after game start comes between `MIN_DELAY_FRAMES`+1 and `MIN_DELAY_FRAMES`+2^`DELAY_RANGE_BITS` frames later.
- Explosion lasts exactly `EXPLODE_FRAMES` `startOfFrame` pulses.
- A `playerShot` in the same cycle as the hit is not counted toward that hit's score.
- Asserting `reset` mid-pass clears all state immediately. It is asynchronous.

## Structure
- Shared package `bonus_ship_pkg`:
  - state enum `bonus_state_t`
  - `SCORE_TABLE`: 15 entries, 9 bits each = {100,50,50,100,150,100,100,50,300,100,100,100,50,150,100}
  - LFSR tap constant
- One sub-module: `lfsr16` (seeded, free-running, 16-bit output).
- Frame counters, FSM and score lookup stay in the top level.

## Test plan
- Reset asserted mid-FLYING → next cycle: all outputs 0, state IDLE, LFSR = 16'hACE1.
- `MIN_DELAY_FRAMES`=4, `DELAY_RANGE_BITS`=1, `playGame` raised → `spawn` is a single pulse after the 5th or 6th `startOfFrame`, and `shipActive`=1.
- 8 `playerShot` pulses, then collision in FLYING → `scoreValid` pulse with `scoreValue`=300, `explodeActive` high for exactly 30 frames, then WAIT.
- Counter expires while `alienMatrixYPosition`=400 → no spawn. Lower Y to 300 → `spawn` on the next frame.
- `bonusFireCollision` and `shipExited` in the same cycle → EXPLODE with a score pulse, no delay reload. A collision pulse while in WAIT → ignored.
- `playGame` dropped during EXPLODE → IDLE next cycle, `explodeActive`=0. 15 shots wrap the counter to 0 (score 100).
